// File: rtl/dsd_mem_pkg.sv
// Shared types for the data-memory side of dsd_processor: address/data widths,
// store-buffer entry layout and the store-buffer control state.
package dsd_mem_pkg;

    localparam int SB_AW = 16;
    localparam int SB_DW = 32;

    typedef logic [SB_AW-3:0] word_addr_t;

    typedef struct packed {
        word_addr_t        addr;
        logic [SB_DW-1:0]  data;
    } sb_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FENCE = 1'b1
    } sb_state_e;

endpackage

// File: rtl/sb_fifo.sv
// DEPTH-entry register FIFO for the store buffer. Besides push/pop it exposes every
// entry in age order (index 0 = head) with a valid mask so the forward comparator can search it.
module sb_fifo
    import dsd_mem_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = sb_entry_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  entry_t                     push_data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output entry_t                     head_o,
    output entry_t                     entries_o [DEPTH],
    output logic [DEPTH-1:0]           valid_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            do_push;
    logic            do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            entries_o[k] = mem_q[rd_ptr_q + PW'(k)];
            valid_o[k]   = CW'(k) < count_q;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write buffer between the processor data port and dmem: stores retire in one
// cycle, drain when the port is free, and matching loads are forwarded from the buffer.
module dmem_store_buffer
    import dsd_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   cpu_addr,
    input  logic [DW-1:0]   cpu_wdata,
    input  logic            cpu_wr,
    input  logic            cpu_rd,
    input  logic            cpu_fence,
    output logic [DW-1:0]   cpu_rdata,
    output logic            cpu_stall,
    output logic [AW-3:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic            mem_wr,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-3:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t            entries [DEPTH];
    entry_t            head;
    logic [DEPTH-1:0]  valid;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_after;

    sb_state_e         state_q, state_d;
    logic              fwd_sel_q, fwd_sel_d;
    logic              rvalid_q, rvalid_d;
    logic [DW-1:0]     fwd_data_q, fwd_data_d;

    logic [AW-3:0]     word_addr;
    logic              hit;
    logic [DW-1:0]     hit_data;
    logic              rd_req;
    logic              fence_hold;
    logic              load_port;
    logic              drain;
    logic              push;
    logic              accept_rd;
    logic              unused_addr_bits;

    assign word_addr        = cpu_addr[AW-1:2];
    assign unused_addr_bits = ^cpu_addr[1:0];

    sb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i ({word_addr, cpu_wdata}),
        .pop_i       (drain),
        .count_o     (count),
        .head_o      (head),
        .entries_o   (entries),
        .valid_o     (valid)
    );

    // Later (younger) matches overwrite earlier ones, so the newest store wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[k] && (entries[k].addr == word_addr)) begin
                hit      = 1'b1;
                hit_data = entries[k].data;
            end
        end
    end

    // A simultaneous rd+wr is a store only; reset silences the port and drops any request.
    always_comb begin
        rd_req     = cpu_rd && !cpu_wr;
        fence_hold = (state_q == FENCE) || (cpu_fence && (count != '0));
        load_port  = !reset && rd_req && !fence_hold && !hit;
        drain      = !reset && (count != '0) && !load_port;
        cpu_stall  = !reset && (fence_hold || (cpu_wr && (count == CW'(DEPTH)) && !drain));
        push       = !reset && cpu_wr && !cpu_stall;
        accept_rd  = !reset && rd_req && !cpu_stall;
    end

    always_comb begin
        mem_wr    = drain;
        mem_addr  = '0;
        mem_wdata = '0;
        if (drain) begin
            mem_addr  = head.addr;
            mem_wdata = head.data;
        end else if (load_port) begin
            mem_addr  = word_addr;
        end
    end

    always_comb begin
        count_after = count;
        if (drain && !push) begin
            count_after = count - 1'b1;
        end else if (push && !drain) begin
            count_after = count + 1'b1;
        end
        state_d    = (fence_hold && (count_after != '0)) ? FENCE : RUN;
        rvalid_d   = accept_rd;
        fwd_sel_d  = accept_rd ? hit : fwd_sel_q;
        fwd_data_d = (accept_rd && hit) ? hit_data : fwd_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            fwd_sel_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            fwd_sel_q  <= fwd_sel_d;
            rvalid_q   <= rvalid_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // Outside a load response the data bus is held at zero.
    assign cpu_rdata = !rvalid_q ? '0 : (fwd_sel_q ? fwd_data_q : mem_rdata);

    a_no_rd_wr: assert property (@(posedge clk) disable iff (reset) !(cpu_rd && cpu_wr))
        else $error("dmem_store_buffer: cpu_rd and cpu_wr both high, handled as a store");

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomised scoreboard bench for dmem_store_buffer: a queue-based reference model predicts
// drains and load data, and a separate monitor compares them whenever the DUT presents them.
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [AW-1:0]   cpu_addr = '0;
    logic [DW-1:0]   cpu_wdata = '0;
    logic            cpu_wr = 1'b0;
    logic            cpu_rd = 1'b0;
    logic            cpu_fence = 1'b0;
    logic [DW-1:0]   cpu_rdata;
    logic            cpu_stall;
    logic [AW-3:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_wr;
    logic [DW-1:0]   mem_rdata = '0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic [AW-3:0] a;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } rsp_t;

    ent_t pq[$];
    ent_t expDrainQ[$];
    rsp_t expRdQ[$];
    bit   inFence = 1'b0;

    logic [DW-1:0] dmem   [bit [AW-3:0]];
    logic [DW-1:0] refMem [bit [AW-3:0]];

    dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wr    (cpu_wr),
        .cpu_rd    (cpu_rd),
        .cpu_fence (cpu_fence),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] initWord(input logic [AW-3:0] a);
        return {16'hC0DE, 2'b00, a};
    endfunction

    function automatic logic [DW-1:0] dmemRead(input logic [AW-3:0] a);
        return dmem.exists(a) ? dmem[a] : initWord(a);
    endfunction

    function automatic logic [DW-1:0] refRead(input logic [AW-3:0] a);
        return refMem.exists(a) ? refMem[a] : initWord(a);
    endfunction

    // Synchronous-read dmem: old data is returned, then the write lands.
    always @(posedge clk) begin
        mem_rdata <= dmemRead(mem_addr);
        if (mem_wr === 1'b1) dmem[mem_addr] = mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    // One clock cycle: drive, predict from the model, check the port, then advance the model.
    task automatic applyStimulus(input bit rst, input bit wr, input bit rd, input bit fence,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                 output bit accepted);
        logic [AW-3:0] wa;
        logic [DW-1:0] fwd;
        bit            hit, loadPort, drain, stall;
        int            n;
        @(posedge clk);
        #1;
        reset = rst; cpu_wr = wr; cpu_rd = rd; cpu_fence = fence;
        cpu_addr = addr; cpu_wdata = data;
        @(negedge clk);
        wa  = addr[AW-1:2];
        n   = pq.size();
        hit = 1'b0;
        fwd = '0;
        foreach (pq[i]) if (pq[i].a == wa) begin hit = 1'b1; fwd = pq[i].d; end
        if (rst) begin
            checkOutput("stall_in_reset", cpu_stall, 1'b0);
            checkOutput("mem_wr_in_reset", mem_wr, 1'b0);
            pq.delete();
            expDrainQ.delete();
            inFence  = 1'b0;
            accepted = 1'b0;
            return;
        end
        loadPort = rd && !wr && !inFence && !(fence && n > 0) && !hit;
        drain    = (n > 0) && !loadPort;
        stall    = inFence || (fence && n > 0) || (wr && n == DEPTH && !drain);
        checkOutput("stall", cpu_stall, stall);
        checkOutput("mem_wr", mem_wr, drain);
        if (loadPort) checkOutput("load_mem_addr", mem_addr, wa);
        if (!drain && !loadPort) begin
            checkOutput("idle_mem_addr", mem_addr, 0);
            checkOutput("idle_mem_wdata", mem_wdata, 0);
        end
        accepted = !stall;
        if (accepted && rd && !wr) expRdQ.push_back('{cyc + 1, hit ? fwd : refRead(wa)});
        if (drain) begin
            refMem[pq[0].a] = pq[0].d;
            void'(pq.pop_front());
        end
        if (accepted && wr) begin
            pq.push_back('{wa, data});
            expDrainQ.push_back('{wa, data});
        end
        inFence = (inFence || (fence && n > 0)) && (pq.size() != 0);
    endtask

    task automatic fenceUntilDone();
        bit ok;
        int tries;
        tries = 0;
        do begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, ok);
            tries++;
        end while (!ok && tries < 20);
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL fence_timeout: still stalled after %0d cycles, expected release", tries);
        end
    endtask

    // Monitor: compares drains in store order and load data on its due cycle.
    initial begin
        forever begin
            ent_t e;
            rsp_t r;
            @(negedge clk);
            #2;
            if (mem_wr === 1'b1) begin
                if (expDrainQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL drain_unexpected (cycle %0d): got write 0x%0h@0x%0h, expected no write",
                             cyc, mem_wdata, mem_addr);
                end else begin
                    e = expDrainQ.pop_front();
                    checkOutput("drain_addr", mem_addr, e.a);
                    checkOutput("drain_data", mem_wdata, e.d);
                end
            end
            if (expRdQ.size() > 0 && expRdQ[0].due <= cyc) begin
                r = expRdQ.pop_front();
                checkOutput("load_data", cpu_rdata, r.d);
            end
        end
    end

    initial begin
        bit            ok, acc, w, r, f, rs;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            sel;

        // Reset and the directed scenarios
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, ok);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, ok);
        checkOutput("rdata_after_reset", cpu_rdata, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 32'hA5A5_0001, ok);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, ok);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, ok);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0000_0011, ok);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0020, '0, ok);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, ok);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0030, 32'd1, ok);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, '0, ok);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0030, 32'd2, ok);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0040, '0, ok);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0032, '0, ok);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, ok);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i * 4), '0, ok);
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0200 + 16'(i * 4), 32'hBEEF_0000 + i, ok);
        end
        fenceUntilDone();
        fenceUntilDone();

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0050, 32'h5555_0050, ok);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0054, 32'h5555_0054, ok);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0050, '0, ok);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0054, '0, ok);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, ok);

        // Random traffic; a stalled request is held until it is accepted
        acc = 1'b1;
        w = 1'b0; r = 1'b0; f = 1'b0; rs = 1'b0; a = '0; d = '0;
        for (int i = 0; i < 1500; i++) begin
            if (acc) begin
                sel = $urandom_range(0, 99);
                rs  = sel < 2;
                f   = sel >= 2 && sel < 8;
                w   = sel >= 8 && sel < 50;
                r   = sel >= 50 && sel < 85;
                a   = (16'($urandom_range(0, 11)) << 2) | 16'($urandom_range(0, 3));
                d   = $urandom;
            end
            applyStimulus(rs, w, r, f, a, d, acc);
            if (rs) acc = 1'b1;
        end

        fenceUntilDone();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, ok);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, ok);
        checkOutput("drain_queue_empty", expDrainQ.size(), 0);
        checkOutput("load_queue_empty", expRdQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
